// File: rtl/inst_mem_loadable_pkg.sv
// Shared constants and helpers for the loadable instruction memory.
// Defaults mirror the values historically kept in head.v.
package inst_mem_loadable_pkg;

    localparam int unsigned LENGTH           = 32;
    localparam int unsigned INST_MEM_LENGTH  = 1024;
    localparam int unsigned INST_MEM_ADDRESS = 10;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    localparam int unsigned ERR_MISALIGN = 0;
    localparam int unsigned ERR_RANGE    = 1;

    // Classify a fetch byte address against a memory of 2**aw words.
    function automatic logic [1:0] fetch_err(
        input logic [31:0] pc,
        input int unsigned aw
    );
        logic [31:0] hi;
        logic [1:0]  e;
        hi = pc >> (aw + 2);
        e = 2'b00;
        e[ERR_MISALIGN] = (pc[1:0] != 2'b00);
        e[ERR_RANGE]    = (hi != 32'd0);
        return e;
    endfunction

endpackage

// File: rtl/inst_mem_loadable_if.sv
// Fetch-side request/response bus of the instruction memory.
// The core is the master, the memory is the slave.
interface inst_mem_loadable_if #(
    parameter int unsigned DATA_W = 32
);

    logic              req_valid;
    logic [31:0]       req_pc;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_instr;
    logic [1:0]        resp_err;
    logic              resp_ready;
    logic              flush;

    modport master (
        output req_valid,
        output req_pc,
        output resp_ready,
        output flush,
        input  req_ready,
        input  resp_valid,
        input  resp_instr,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_pc,
        input  resp_ready,
        input  flush,
        output req_ready,
        output resp_valid,
        output resp_instr,
        output resp_err
    );

endinterface

// File: rtl/inst_mem_loadable_imem_sync_ram.sv
// Single-write, single synchronous-read word RAM without reset.
// The read register only updates on rd_en so a held word stays stable.
module imem_sync_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port: boot loader stores one word per enabled cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered word, held until the next read.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_mem_loadable.sv
// Instruction memory filled through a streaming boot-load port,
// then served to the fetch stage with a one-cycle read latency.
module inst_mem_loadable
    import inst_mem_loadable_pkg::*;
#(
    parameter int unsigned       DATA_W   = LENGTH,
    parameter int unsigned       DEPTH    = INST_MEM_LENGTH,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ovf,
    output logic              booted,
    inst_mem_loadable_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W:0]   ld_ptr;
    logic              ld_full;
    logic              ld_fire;
    logic              wr_en;

    logic              accept;
    logic [1:0]        req_err;
    logic              resp_valid_q;
    logic [1:0]        resp_err_q;
    logic              resp_hit_q;
    logic [DATA_W-1:0] rd_data;

    // The pointer saturates at DEPTH, so its top bit alone means full.
    assign ld_full = ld_ptr[ADDR_W];
    assign ld_fire = (state_q == BOOT) && ld_valid;
    assign wr_en   = ld_fire && !ld_full;

    // State register for the boot/run controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave BOOT on the last load word, even a dropped one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT: begin
                if (ld_valid && ld_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Load pointer advances per stored word; overflow flag is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_ptr <= '0;
            ld_ovf <= 1'b0;
        end else if (ld_fire) begin
            if (ld_full) begin
                ld_ovf <= 1'b1;
            end else begin
                ld_ptr <= ld_ptr + (ADDR_W + 1)'(1);
            end
        end
    end

    assign booted = (state_q == RUN);

    assign bus.req_ready = (state_q == RUN) && !bus.flush &&
                           (!resp_valid_q || bus.resp_ready);
    assign accept  = bus.req_valid && bus.req_ready;
    assign req_err = fetch_err(bus.req_pc, ADDR_W);

    imem_sync_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(ld_ptr[ADDR_W-1:0]),
        .wr_data(ld_data),
        .rd_en  (accept),
        .rd_addr(bus.req_pc[ADDR_W+1:2]),
        .rd_data(rd_data)
    );

    // Response holder: load on accept, drop on consume or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 2'b00;
            resp_hit_q   <= 1'b0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= req_err;
            resp_hit_q   <= (req_err == 2'b00);
        end else if (bus.flush || bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    // RAM output is only exposed for a clean read; otherwise NOP.
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_instr = resp_hit_q ? rd_data : NOP_WORD;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Randomized bench for inst_mem_loadable against a behavioural model.
// A second DEPTH=4 instance covers load overflow.
module tb_inst_mem_loadable;

    localparam int unsigned DEPTH_A = 1024;
    localparam logic [31:0] NOP_A   = 32'h0000_0013;
    localparam logic [31:0] NOP_B   = 32'hFFFF_0013;

    logic        clk;
    logic        rst;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ovf;
    logic        booted;

    logic        ld4_valid;
    logic [31:0] ld4_data;
    logic        ld4_last;
    logic        ld4_ovf;
    logic        booted4;

    int n_checks;
    int n_errors;

    logic [31:0] m_mem [DEPTH_A];
    int          m_ptr;
    bit          m_ovf;
    bit          m_booted;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [1:0]  m_err;

    inst_mem_loadable_if #(.DATA_W(32)) bus ();
    inst_mem_loadable_if #(.DATA_W(32)) bus4 ();

    inst_mem_loadable #(
        .DATA_W  (32),
        .DEPTH   (DEPTH_A),
        .NOP_WORD(NOP_A)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ld_valid(ld_valid),
        .ld_data (ld_data),
        .ld_last (ld_last),
        .ld_ovf  (ld_ovf),
        .booted  (booted),
        .bus     (bus)
    );

    inst_mem_loadable #(
        .DATA_W  (32),
        .DEPTH   (4),
        .NOP_WORD(NOP_B)
    ) dut4 (
        .clk     (clk),
        .rst     (rst),
        .ld_valid(ld4_valid),
        .ld_data (ld4_data),
        .ld_last (ld4_last),
        .ld_ovf  (ld4_ovf),
        .booted  (booted4),
        .bus     (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected response for a fetch, from the address rules alone.
    task automatic ref_fetch(input logic [31:0] pc, output logic [31:0] instr,
                             output logic [1:0] err);
        err[0] = (pc % 4) != 0;
        err[1] = pc >= 4 * DEPTH_A;
        instr  = (err != 2'b00) ? NOP_A : m_mem[pc / 4];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ld_valid = 1'b0;
        ld_last = 1'b0;
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
        bus.flush = 1'b0;
        ld4_valid = 1'b0;
        ld4_last = 1'b0;
        bus4.req_valid = 1'b0;
        bus4.resp_ready = 1'b0;
        bus4.flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ptr = 0;
        m_ovf = 0;
        m_booted = 0;
        m_valid = 0;
        check("rst_booted", 32'(booted), 32'(m_booted));
        check("rst_ld_ptr", 32'(dut.ld_ptr), 32'd0);
        check("rst_ld_ovf", 32'(ld_ovf), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_resp_instr", bus.resp_instr, NOP_A);
    endtask

    task automatic load_cycle(input bit v, input logic [31:0] d, input bit last);
        ld_valid = v;
        ld_data = d;
        ld_last = last;
        @(posedge clk);
        if (!m_booted && v) begin
            if (m_ptr < DEPTH_A) begin
                m_mem[m_ptr] = d;
                m_ptr++;
            end else begin
                m_ovf = 1;
            end
            if (last) m_booted = 1;
        end
        #1;
        ld_valid = 1'b0;
        ld_last = 1'b0;
        check("booted", 32'(booted), 32'(m_booted));
        check("ld_ovf", 32'(ld_ovf), 32'(m_ovf));
    endtask

    task automatic fetch_cycle(input bit v, input logic [31:0] pc,
                               input bit rr, input bit fl);
        bit exp_ready;
        bus.req_valid = v;
        bus.req_pc = pc;
        bus.resp_ready = rr;
        bus.flush = fl;
        #3;
        exp_ready = m_booted && !fl && (!m_valid || rr);
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("resp_valid", 32'(bus.resp_valid), 32'(m_valid));
        if (m_valid) begin
            check("resp_instr", bus.resp_instr, m_instr);
            check("resp_err", 32'(bus.resp_err), 32'(m_err));
        end
        @(posedge clk);
        if (v && exp_ready) begin
            m_valid = 1;
            ref_fetch(pc, m_instr, m_err);
        end else if (fl || rr) begin
            m_valid = 0;
        end
        #1;
        bus.req_valid = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic fetch4(input logic [31:0] pc, input logic [31:0] exp_i,
                          input logic [1:0] exp_e);
        bus4.req_valid = 1'b1;
        bus4.req_pc = pc;
        bus4.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus4.req_valid = 1'b0;
        #3;
        check("d4_resp_valid", 32'(bus4.resp_valid), 32'd1);
        check("d4_resp_instr", bus4.resp_instr, exp_i);
        check("d4_resp_err", 32'(bus4.resp_err), 32'(exp_e));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w4 [5];
        logic [31:0] pc;
        int n;
        n_checks = 0;
        n_errors = 0;
        ld_data = '0;
        ld4_data = '0;
        bus.req_pc = '0;
        bus4.req_pc = '0;
        do_reset();
        do_reset();

        // Overflow on the DEPTH=4 instance.
        for (int i = 0; i < 4; i++) w4[i] = $urandom | 32'h1000_0000;
        w4[4] = 32'h55;
        for (int i = 0; i < 5; i++) begin
            ld4_valid = 1'b1;
            ld4_data = w4[i];
            ld4_last = (i == 4);
            @(posedge clk);
            #1;
            ld4_valid = 1'b0;
            ld4_last = 1'b0;
            if (i == 3) begin
                check("d4_ovf_early", 32'(ld4_ovf), 32'd0);
                check("d4_booted_early", 32'(booted4), 32'd0);
            end
        end
        check("d4_ovf", 32'(ld4_ovf), 32'd1);
        check("d4_booted", 32'(booted4), 32'd1);
        for (int i = 0; i < 4; i++) fetch4(32'(4 * i), w4[i], 2'b00);
        fetch4(32'd16, NOP_B, 2'b10);
        check("d4_ovf_sticky", 32'(ld4_ovf), 32'd1);

        // Reset mid-load, then reload.
        load_cycle(1, $urandom | 32'h8000_0000, 0);
        load_cycle(1, $urandom | 32'h8000_0000, 0);
        do_reset();
        load_cycle(1, 32'h11, 0);
        load_cycle(1, 32'h22, 0);
        load_cycle(1, 32'h33, 0);
        load_cycle(1, 32'h44, 1);
        check("booted_after_load", 32'(booted), 32'd1);

        fetch_cycle(1, 32'h8, 1, 0);
        fetch_cycle(1, 32'h4, 1, 0);
        fetch_cycle(1, 32'h6, 1, 0);
        fetch_cycle(1, 32'(4 * DEPTH_A), 1, 0);
        fetch_cycle(0, 32'h0, 1, 0);

        // Back-pressure, then streaming.
        fetch_cycle(1, 32'h0, 0, 0);
        repeat (3) fetch_cycle(1, 32'h0, 0, 0);
        fetch_cycle(1, 32'h0, 1, 0);
        fetch_cycle(1, 32'h4, 1, 0);
        fetch_cycle(1, 32'h8, 1, 0);
        fetch_cycle(0, 32'h0, 1, 0);

        // Flush beats resp_ready and blocks the new request.
        fetch_cycle(1, 32'hC, 0, 0);
        fetch_cycle(1, 32'h4, 1, 1);
        fetch_cycle(1, 32'h4, 1, 0);
        fetch_cycle(0, 32'h0, 1, 0);

        // Load port is dead in RUN.
        load_cycle(1, 32'hBAD0_0000, 0);
        load_cycle(1, 32'hBAD0_0001, 1);
        check("ld_ptr_run", 32'(dut.ld_ptr), 32'(m_ptr));
        for (int i = 0; i < 4; i++) fetch_cycle(1, 32'(4 * i), 1, 0);
        fetch_cycle(0, 32'h0, 1, 0);

        // Random load and random fetch traffic.
        do_reset();
        n = $urandom_range(8, 40);
        for (int i = 0; i < n; i++) load_cycle(1, $urandom, i == n - 1);
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 9))
                0: pc = 32'(4 * $urandom_range(0, n - 1) + $urandom_range(1, 3));
                1: pc = $urandom | 32'h0000_1000;
                default: pc = 32'(4 * $urandom_range(0, n - 1));
            endcase
            fetch_cycle($urandom_range(0, 3) != 0, pc,
                        $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
